// File: rtl/fft_pkg.sv
// Shared types and elaboration helpers for the FFT peak tracker.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    FLUSH  = 2'd2,
    DECIDE = 2'd3
  } state_e;

  // Width of |re| + |im| without overflow.
  function automatic int unsigned mag_w(input int unsigned bit_width);
    return bit_width + 1;
  endfunction

  // Scan window must be non-empty, within the lower half-spectrum, and addressable.
  function automatic bit params_legal(input int unsigned n,
                                      input int unsigned fft_size,
                                      input int unsigned min_bin,
                                      input int unsigned max_bin,
                                      input int unsigned stable_frames);
    return (fft_size == (32'd1 << n)) && (min_bin <= max_bin) &&
           (max_bin < fft_size / 2) && (stable_frames >= 1);
  endfunction

endpackage

// File: rtl/note_stabilizer.sv
// Debounces per-frame peaks into a held note decision with assert/release hysteresis.
module note_stabilizer #(
  parameter int unsigned N             = 9,
  parameter int unsigned TOL           = 1,
  parameter int unsigned STABLE_FRAMES = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_i,
  input  logic         found_i,
  input  logic [N-1:0] bin_i,
  output logic         note_dec,
  output logic [N-1:0] note_bin
);

  localparam int unsigned CW = $clog2(STABLE_FRAMES + 1);
  localparam logic [CW-1:0] SAT = CW'(STABLE_FRAMES);

  logic [N-1:0]  cand_bin_q, cand_bin_d;
  logic [CW-1:0] stable_cnt_q, stable_cnt_d;
  logic [CW-1:0] miss_cnt_q, miss_cnt_d;
  logic          note_dec_q, note_dec_d;
  logic [N-1:0]  note_bin_q, note_bin_d;
  logic [N-1:0]  diff_c;
  logic          match_c;

  always_comb begin
    diff_c  = (bin_i >= cand_bin_q) ? (bin_i - cand_bin_q) : (cand_bin_q - bin_i);
    match_c = found_i && (32'(diff_c) <= TOL);
  end

  // Frame-to-frame tracking; a new stable note overwrites note_bin without dropping note_dec.
  always_comb begin
    cand_bin_d   = cand_bin_q;
    stable_cnt_d = stable_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    note_dec_d   = note_dec_q;
    note_bin_d   = note_bin_q;
    if (valid_i) begin
      if (found_i) begin
        miss_cnt_d = '0;
        if (match_c) begin
          stable_cnt_d = (stable_cnt_q == SAT) ? SAT : stable_cnt_q + CW'(1);
        end else begin
          cand_bin_d   = bin_i;
          stable_cnt_d = CW'(1);
        end
        if (stable_cnt_d == SAT) begin
          note_dec_d = 1'b1;
          note_bin_d = bin_i;
        end
      end else begin
        stable_cnt_d = '0;
        miss_cnt_d   = (miss_cnt_q == SAT) ? SAT : miss_cnt_q + CW'(1);
        if (miss_cnt_d == SAT) begin
          note_dec_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cand_bin_q   <= '0;
      stable_cnt_q <= '0;
      miss_cnt_q   <= '0;
      note_dec_q   <= 1'b0;
      note_bin_q   <= '0;
    end else begin
      cand_bin_q   <= cand_bin_d;
      stable_cnt_q <= stable_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      note_dec_q   <= note_dec_d;
      note_bin_q   <= note_bin_d;
    end
  end

  assign note_dec = note_dec_q;
  assign note_bin = note_bin_q;

endmodule

// File: rtl/fft_peak_tracker.sv
// Scans a bin window of the FFT result RAM, finds the strongest L1-magnitude bin
// above a threshold, and feeds it to the note stabilizer.
module fft_peak_tracker
  import fft_pkg::*;
#(
  parameter int unsigned BIT_WIDTH     = 16,
  parameter int unsigned N             = 9,
  parameter int unsigned FFT_SIZE      = 512,
  parameter int unsigned MIN_BIN       = 4,
  parameter int unsigned MAX_BIN       = 255,
  parameter int unsigned TOL           = 1,
  parameter int unsigned STABLE_FRAMES = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          fft_done,
  output logic [N-1:0]                  rd_addr,
  input  logic signed [BIT_WIDTH-1:0]   re_in,
  input  logic signed [BIT_WIDTH-1:0]   im_in,
  input  logic [mag_w(BIT_WIDTH)-1:0]   threshold,
  output logic                          busy,
  output logic                          peak_valid,
  output logic                          peak_found,
  output logic [N-1:0]                  peak_bin,
  output logic [mag_w(BIT_WIDTH)-1:0]   peak_mag,
  output logic                          note_dec,
  output logic [N-1:0]                  note_bin,
  output logic                          overrun
);

  localparam int unsigned MW = mag_w(BIT_WIDTH);
  localparam logic [N-1:0] MIN_ADDR = N'(MIN_BIN);
  localparam logic [N-1:0] MAX_ADDR = N'(MAX_BIN);

  if (!params_legal(N, FFT_SIZE, MIN_BIN, MAX_BIN, STABLE_FRAMES)) begin : g_param_check
    $error("fft_peak_tracker: illegal bin window or size parameters");
  end

  state_e            state_q, state_d;
  logic [N-1:0]      rd_addr_q, rd_addr_d;
  logic              cmp_en_q, cmp_en_d;
  logic [N-1:0]      cmp_bin_q, cmp_bin_d;
  logic [MW-1:0]     thr_q, thr_d;
  logic [MW-1:0]     max_mag_q, max_mag_d;
  logic [N-1:0]      max_bin_q, max_bin_d;
  logic              busy_q, busy_d;
  logic              peak_valid_q, peak_valid_d;
  logic              peak_found_q, peak_found_d;
  logic [N-1:0]      peak_bin_q, peak_bin_d;
  logic [MW-1:0]     peak_mag_q, peak_mag_d;
  logic              overrun_q, overrun_d;
  logic [BIT_WIDTH-1:0] abs_re_c, abs_im_c;
  logic [MW-1:0]     mag_c;

  // RAM output register holds the sample; magnitude is formed straight from it.
  always_comb begin
    abs_re_c = re_in[BIT_WIDTH-1] ? $unsigned(-re_in) : $unsigned(re_in);
    abs_im_c = im_in[BIT_WIDTH-1] ? $unsigned(-im_in) : $unsigned(im_in);
    mag_c    = MW'(abs_re_c) + MW'(abs_im_c);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fft_done) state_d = SCAN;
      SCAN:    if (rd_addr_q == MAX_ADDR) state_d = FLUSH;
      FLUSH:   state_d = DECIDE;
      DECIDE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_addr_d    = rd_addr_q;
    cmp_en_d     = (state_q == SCAN);
    cmp_bin_d    = rd_addr_q;
    thr_d        = thr_q;
    max_mag_d    = max_mag_q;
    max_bin_d    = max_bin_q;
    busy_d       = (state_d != IDLE);
    peak_valid_d = 1'b0;
    peak_found_d = peak_found_q;
    peak_bin_d   = peak_bin_q;
    peak_mag_d   = peak_mag_q;
    overrun_d    = fft_done && (state_q != IDLE);

    // Strict compare keeps the lowest bin on ties.
    if (cmp_en_q && (mag_c > max_mag_q)) begin
      max_mag_d = mag_c;
      max_bin_d = cmp_bin_q;
    end

    case (state_q)
      IDLE: begin
        if (fft_done) begin
          rd_addr_d = MIN_ADDR;
          thr_d     = threshold;
          max_mag_d = '0;
          max_bin_d = '0;
        end
      end
      SCAN: begin
        if (rd_addr_q != MAX_ADDR) rd_addr_d = rd_addr_q + N'(1);
      end
      DECIDE: begin
        peak_valid_d = 1'b1;
        peak_found_d = (max_mag_q >= thr_q);
        peak_bin_d   = peak_found_d ? max_bin_q : '0;
        peak_mag_d   = peak_found_d ? max_mag_q : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_addr_q    <= '0;
      cmp_en_q     <= 1'b0;
      cmp_bin_q    <= '0;
      thr_q        <= '0;
      max_mag_q    <= '0;
      max_bin_q    <= '0;
      busy_q       <= 1'b0;
      peak_valid_q <= 1'b0;
      peak_found_q <= 1'b0;
      peak_bin_q   <= '0;
      peak_mag_q   <= '0;
      overrun_q    <= 1'b0;
    end else begin
      rd_addr_q    <= rd_addr_d;
      cmp_en_q     <= cmp_en_d;
      cmp_bin_q    <= cmp_bin_d;
      thr_q        <= thr_d;
      max_mag_q    <= max_mag_d;
      max_bin_q    <= max_bin_d;
      busy_q       <= busy_d;
      peak_valid_q <= peak_valid_d;
      peak_found_q <= peak_found_d;
      peak_bin_q   <= peak_bin_d;
      peak_mag_q   <= peak_mag_d;
      overrun_q    <= overrun_d;
    end
  end

  note_stabilizer #(
    .N            (N),
    .TOL          (TOL),
    .STABLE_FRAMES(STABLE_FRAMES)
  ) u_stab (
    .clk     (clk),
    .reset   (reset),
    .valid_i (peak_valid_d),
    .found_i (peak_found_d),
    .bin_i   (peak_bin_d),
    .note_dec(note_dec),
    .note_bin(note_bin)
  );

  assign rd_addr    = rd_addr_q;
  assign busy       = busy_q;
  assign peak_valid = peak_valid_q;
  assign peak_found = peak_found_q;
  assign peak_bin   = peak_bin_q;
  assign peak_mag   = peak_mag_q;
  assign overrun    = overrun_q;

endmodule
